// File: rtl/fp_normalizer.sv
`default_nettype none
// ============================================================================
// fp_normalizer : post-add/sub mantissa normalization, 2-stage valid/ready pipe
// Optional build macro FP_NORM_SUBNORMAL_EN: denormal results instead of flush
// Revision      : 1.0
// ============================================================================
module fp_normalizer #(
  parameter int MANT_W  = 32,
  parameter int EXP_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [MANT_W-1:0]  in_mant,
  input  logic [MANT_W-1:0]  in_lead,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MANT_W-1:0]  out_mant,
  output logic               out_zero,
  output logic               out_overflow,
  output logic               out_underflow
);

  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0]     c_exp_max  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0]     c_exp_one  = XW'(1);
  localparam logic [MANT_W-1:0]        c_mant_msk = {1'b0, {(MANT_W-1){1'b1}}};
  localparam logic [SHIFT_W-1:0]       c_top_pos  = SHIFT_W'(MANT_W - 2);

  // ---------------- stage 1: leading-one encode ----------------
  logic [SHIFT_W-1:0] w_pos;
  logic               w_found;
  logic               w_right;
  logic [SHIFT_W-1:0] w_sh;

  always_comb begin
    w_pos   = '0;
    w_found = 1'b0;
    for (int i = 0; i < MANT_W; i++) begin
      if (in_lead[i]) begin
        w_pos   = SHIFT_W'(i);
        w_found = 1'b1;
      end
    end
    w_right = w_found && (w_pos == SHIFT_W'(MANT_W - 1));
    w_sh    = (w_found && !w_right) ? (c_top_pos - w_pos) : '0;
  end

  logic               r_s1_valid;
  logic               r_s1_sign;
  logic [EXP_W-1:0]   r_s1_exp;
  logic [MANT_W-1:0]  r_s1_mant;
  logic               r_s1_zero;
  logic               r_s1_right;
  logic [SHIFT_W-1:0] r_s1_sh;

  logic               r_s2_valid;
  logic               r_s2_sign;
  logic [EXP_W-1:0]   r_s2_exp;
  logic [MANT_W-1:0]  r_s2_mant;
  logic               r_s2_zero;
  logic               r_s2_ovf;
  logic               r_s2_unf;

  logic w_s1_move;
  assign w_s1_move = !r_s2_valid || out_ready;
  assign in_ready  = !rst && (!r_s1_valid || w_s1_move);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mant  <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_right <= 1'b0;
      r_s1_sh    <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign  <= in_sign;
        r_s1_exp   <= in_exp;
        r_s1_mant  <= in_mant;
        r_s1_zero  <= !w_found;
        r_s1_right <= w_right;
        r_s1_sh    <= w_sh;
      end
    end
  end

  // ---------------- stage 2: shift and exponent adjust ----------------
  logic signed [XW-1:0] w_exp_in;
  logic signed [XW-1:0] w_sh_x;
  logic signed [XW-1:0] w_exp_adj;
  logic [MANT_W-1:0]    w_mant_norm;
  logic [MANT_W-1:0]    w_mant_unf;
  logic                 w_ovf;
  logic                 w_unf;
  logic [EXP_W-1:0]     w_exp_out;
  logic [MANT_W-1:0]    w_mant_out;

`ifdef FP_NORM_SUBNORMAL_EN
  logic [EXP_W-1:0] w_lim;
  // Denormal: shift only as far as the exponent can absorb, landing at exp 0.
  assign w_lim      = (r_s1_exp == '0) ? '0 : (r_s1_exp - EXP_W'(1));
  assign w_mant_unf = r_s1_mant << w_lim;
`else
  assign w_mant_unf = '0;
`endif

  always_comb begin
    w_exp_in    = $signed({2'b00, r_s1_exp});
    w_sh_x      = XW'(r_s1_sh);
    w_exp_adj   = r_s1_right ? (w_exp_in + c_exp_one) : (w_exp_in - w_sh_x);
    w_mant_norm = r_s1_right ? ((r_s1_mant >> 1) | {{(MANT_W-1){1'b0}}, r_s1_mant[0]})
                             : (r_s1_mant << r_s1_sh);
    w_ovf       = !r_s1_zero && (w_exp_adj >= c_exp_max);
    w_unf       = !r_s1_zero && !w_ovf && (w_exp_adj < c_exp_one);
    w_exp_out   = w_exp_adj[EXP_W-1:0];
    w_mant_out  = w_mant_norm;
    if (r_s1_zero) begin
      w_exp_out  = '0;
      w_mant_out = '0;
    end else if (w_ovf) begin
      w_exp_out  = '1;
      w_mant_out = '0;
    end else if (w_unf) begin
      w_exp_out  = '0;
      w_mant_out = w_mant_unf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_mant  <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_unf   <= 1'b0;
    end else if (w_s1_move) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign  <= r_s1_sign;
        r_s2_exp   <= w_exp_out;
        r_s2_mant  <= w_mant_out & c_mant_msk;
        r_s2_zero  <= r_s1_zero;
        r_s2_ovf   <= w_ovf;
        r_s2_unf   <= w_unf;
      end
    end
  end

  assign out_valid     = r_s2_valid;
  assign out_sign      = r_s2_sign;
  assign out_exp       = r_s2_exp;
  assign out_mant      = r_s2_mant;
  assign out_zero      = r_s2_zero;
  assign out_overflow  = r_s2_ovf;
  assign out_underflow = r_s2_unf;

endmodule
`default_nettype wire
